// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: 8-entry byte FIFO feeding an 8-bit serial frame
// with optional odd/even parity and one or two stop bits.
module uart_tx_buffered #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 38400,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic [3:0] count,
  output logic       TxD,
  output logic       TxD_busy
);

  localparam int BIT_CYCLES = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state, state_next;

  logic [7:0]    mem [8];
  logic [2:0]    wr_ptr, rd_ptr;
  logic [CW-1:0] baud_cnt, baud_next;
  logic [2:0]    bit_cnt, bit_next;
  logic [7:0]    tx_byte, tx_byte_next;
  logic          txd_next;
  logic          push, pop;
  logic          bit_done;
  logic          parity_bit;

  // A write while full is dropped even when the FSM pops in the same cycle.
  assign full       = (count == 4'd8);
  assign push       = wr_en && !full;
  assign TxD_busy   = (state != S_IDLE) || (count != 4'd0);
  assign bit_done   = (baud_cnt == BAUD_LAST);
  assign parity_bit = (PARITY == 1) ? ~(^tx_byte) : (^tx_byte);

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      count  <= 4'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 3'd1;
      if (pop)  rd_ptr <= rd_ptr + 3'd1;
      if (push && !pop) begin
        count <= count + 4'd1;
      end else if (pop && !push) begin
        count <= count - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      tx_byte  <= 8'd0;
      TxD      <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      tx_byte  <= tx_byte_next;
      TxD      <= txd_next;
    end
  end

  // TxD is registered, so the level for the next bit is chosen at the edge
  // that ends the current one.
  always_comb begin
    state_next   = state;
    baud_next    = baud_cnt;
    bit_next     = bit_cnt;
    tx_byte_next = tx_byte;
    txd_next     = TxD;
    pop          = 1'b0;
    case (state)
      S_IDLE: begin
        txd_next  = 1'b1;
        baud_next = '0;
        if (count != 4'd0) begin
          pop          = 1'b1;
          tx_byte_next = mem[rd_ptr];
          bit_next     = 3'd0;
          state_next   = S_START;
          txd_next     = 1'b0;
        end
      end
      S_START: begin
        if (bit_done) begin
          baud_next  = '0;
          state_next = S_DATA;
          txd_next   = tx_byte[0];
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          baud_next = '0;
          if (bit_cnt == 3'd7) begin
            bit_next = 3'd0;
            if (PARITY != 0) begin
              state_next = S_PARITY;
              txd_next   = parity_bit;
            end else begin
              state_next = S_STOP;
              txd_next   = 1'b1;
            end
          end else begin
            bit_next = bit_cnt + 3'd1;
            txd_next = tx_byte[bit_cnt + 3'd1];
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          baud_next  = '0;
          bit_next   = 3'd0;
          state_next = S_STOP;
          txd_next   = 1'b1;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      S_STOP: begin
        txd_next = 1'b1;
        if (bit_done) begin
          baud_next = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_next   = 3'd0;
            state_next = S_IDLE;
          end else begin
            bit_next = bit_cnt + 3'd1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        txd_next   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: three instances (no/odd/even parity)
// at 16 clocks per bit, with per-instance serial monitors decoding TxD.
module tb_uart_tx_buffered;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       b2b;
    logic       last;
  } exp_t;

  logic       clk;
  logic [2:0] rst_v;
  logic [2:0] wr_en_v;
  logic [7:0] wr_data_v [3];
  wire  [2:0] full_v;
  wire  [2:0] txd_v;
  wire  [2:0] busy_v;
  wire  [3:0] count_v [3];

  exp_t exp_q [3][$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_buffered #(.CLK_FREQ(1600), .BAUD(100), .PARITY(0), .STOP_BITS(2)) u_none (
    .clk(clk), .rst(rst_v[0]), .wr_en(wr_en_v[0]), .wr_data(wr_data_v[0]),
    .full(full_v[0]), .count(count_v[0]), .TxD(txd_v[0]), .TxD_busy(busy_v[0])
  );

  uart_tx_buffered #(.CLK_FREQ(1600), .BAUD(100), .PARITY(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst_v[1]), .wr_en(wr_en_v[1]), .wr_data(wr_data_v[1]),
    .full(full_v[1]), .count(count_v[1]), .TxD(txd_v[1]), .TxD_busy(busy_v[1])
  );

  uart_tx_buffered #(.CLK_FREQ(1600), .BAUD(100), .PARITY(2), .STOP_BITS(2)) u_even (
    .clk(clk), .rst(rst_v[2]), .wr_en(wr_en_v[2]), .wr_data(wr_data_v[2]),
    .full(full_v[2]), .count(count_v[2]), .TxD(txd_v[2]), .TxD_busy(busy_v[2])
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input int idx, input logic [7:0] data);
    wr_en_v[idx]   = 1'b1;
    wr_data_v[idx] = data;
    @(posedge clk);
    #1;
    wr_en_v[idx] = 1'b0;
  endtask

  task automatic expect_frame(input int idx, input logic [7:0] data, input logic par,
                              input logic b2b, input logic last);
    exp_t e;
    e.data = data;
    e.par  = par;
    e.b2b  = b2b;
    e.last = last;
    exp_q[idx].push_back(e);
  endtask

  task automatic wait_drain(input int idx, input int budget);
    int n;
    n = 0;
    while ((exp_q[idx].size() != 0 || busy_v[idx] !== 1'b0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output($sformatf("drain_u%0d", idx), (exp_q[idx].size() == 0 && busy_v[idx] === 1'b0), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Decodes frames off one TxD line, checking every cycle of every bit.
  task automatic monitor(input int idx, input bit has_par, input int stops);
    exp_t        e;
    logic [11:0] bits;
    int          nb;
    int          idle;
    bit          aborted;
    logic        seen;
    logic        busy_last;
    idle = 0;
    forever begin
      forever begin
        @(negedge clk);
        if (rst_v[idx]) idle = 0;
        else if (txd_v[idx] === 1'b0) break;
        else idle++;
      end
      check_output($sformatf("u%0d_frame_expected", idx), exp_q[idx].size() != 0, 1);
      if (exp_q[idx].size() != 0) e = exp_q[idx].pop_front();
      else e = '0;
      if (e.b2b) check_output($sformatf("u%0d_idle_gap", idx), idle, 1);
      nb = 0;
      bits = '0;
      bits[nb] = 1'b0;
      nb++;
      for (int i = 0; i < 8; i++) begin
        bits[nb] = e.data[i];
        nb++;
      end
      if (has_par) begin
        bits[nb] = e.par;
        nb++;
      end
      for (int s = 0; s < stops; s++) begin
        bits[nb] = 1'b1;
        nb++;
      end
      aborted   = 1'b0;
      busy_last = 1'b0;
      for (int b = 0; b < nb && !aborted; b++) begin
        seen = bits[b];
        for (int c = 0; c < 16; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (rst_v[idx]) begin
            aborted = 1'b1;
            break;
          end
          if (txd_v[idx] !== bits[b] && seen === bits[b]) seen = txd_v[idx];
          busy_last = busy_v[idx];
        end
        if (!aborted) check_output($sformatf("u%0d_d%0h_bit%0d", idx, e.data, b), seen, bits[b]);
      end
      if (aborted) begin
        idle = 0;
        continue;
      end
      check_output($sformatf("u%0d_busy_in_frame", idx), busy_last, 1);
      @(negedge clk);
      if (rst_v[idx]) begin
        idle = 0;
        continue;
      end
      check_output($sformatf("u%0d_idle_txd", idx), txd_v[idx], 1);
      if (e.last) check_output($sformatf("u%0d_busy_after_frame", idx), busy_v[idx], 0);
      idle = 1;
    end
  endtask

  initial monitor(0, 1'b0, 2);
  initial monitor(1, 1'b1, 1);
  initial monitor(2, 1'b1, 2);

  initial begin
    logic [3:0] cnt_tab [9];
    cnt_tab = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8};

    // Reset with write strobes held high: writes must be ignored.
    rst_v   = 3'b111;
    wr_en_v = 3'b111;
    for (int i = 0; i < 3; i++) wr_data_v[i] = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("reset_txd_u%0d", i), txd_v[i], 1);
      check_output($sformatf("reset_busy_u%0d", i), busy_v[i], 0);
      check_output($sformatf("reset_count_u%0d", i), count_v[i], 0);
      check_output($sformatf("reset_full_u%0d", i), full_v[i], 0);
    end
    rst_v   = 3'b000;
    wr_en_v = 3'b000;
    @(posedge clk);
    #1;

    $display("[TB] single 0x55 frame, no parity");
    expect_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    apply_stimulus(0, 8'h55);
    wait_drain(0, 400);

    $display("[TB] parity frames, back to back");
    expect_frame(2, 8'h07, 1'b1, 1'b0, 1'b0);
    expect_frame(2, 8'hA5, 1'b0, 1'b1, 1'b1);
    expect_frame(1, 8'h07, 1'b0, 1'b0, 1'b0);
    expect_frame(1, 8'hA5, 1'b1, 1'b1, 1'b1);
    apply_stimulus(2, 8'h07);
    apply_stimulus(2, 8'hA5);
    apply_stimulus(1, 8'h07);
    apply_stimulus(1, 8'hA5);
    wait_drain(2, 800);
    wait_drain(1, 800);

    $display("[TB] overfill FIFO during a frame");
    expect_frame(0, 8'h20, 1'b0, 1'b0, 1'b0);
    apply_stimulus(0, 8'h20);
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) expect_frame(0, 8'h10 + 8'(i), 1'b0, 1'b1, (i == 7));
      apply_stimulus(0, 8'h10 + 8'(i));
      check_output($sformatf("fill_count_%0d", i), count_v[0], cnt_tab[i]);
      check_output($sformatf("fill_full_%0d", i), full_v[0], (i >= 7));
    end
    wait_drain(0, 3000);

    $display("[TB] write while full during IDLE pop");
    expect_frame(0, 8'h30, 1'b0, 1'b0, 1'b0);
    apply_stimulus(0, 8'h30);
    for (int i = 0; i < 8; i++) begin
      expect_frame(0, 8'h31 + 8'(i), 1'b0, 1'b1, (i == 7));
      apply_stimulus(0, 8'h31 + 8'(i));
    end
    check_output("prepop_count_early", count_v[0], 8);
    repeat (169) @(posedge clk);
    #1;
    check_output("prepop_count", count_v[0], 8);
    check_output("prepop_full", full_v[0], 1);
    apply_stimulus(0, 8'h99);
    check_output("pop_drop_count", count_v[0], 7);
    check_output("pop_drop_full", full_v[0], 0);
    wait_drain(0, 3000);

    $display("[TB] reset mid-frame with bytes queued");
    expect_frame(0, 8'h41, 1'b0, 1'b0, 1'b0);
    expect_frame(0, 8'h42, 1'b0, 1'b1, 1'b0);
    expect_frame(0, 8'h43, 1'b0, 1'b1, 1'b0);
    expect_frame(0, 8'h44, 1'b0, 1'b1, 1'b1);
    apply_stimulus(0, 8'h41);
    apply_stimulus(0, 8'h42);
    apply_stimulus(0, 8'h43);
    apply_stimulus(0, 8'h44);
    check_output("queued_count", count_v[0], 3);
    repeat (68) @(posedge clk);
    #1;
    rst_v[0]     = 1'b1;
    wr_en_v[0]   = 1'b1;
    wr_data_v[0] = 8'h77;
    exp_q[0].delete();
    @(posedge clk);
    #1;
    rst_v[0]   = 1'b0;
    wr_en_v[0] = 1'b0;
    check_output("abort_txd", txd_v[0], 1);
    check_output("abort_count", count_v[0], 0);
    check_output("abort_full", full_v[0], 0);
    check_output("abort_busy", busy_v[0], 0);
    repeat (400) @(posedge clk);
    #1;
    check_output("post_abort_txd", txd_v[0], 1);
    check_output("post_abort_busy", busy_v[0], 0);
    check_output("post_abort_count", count_v[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
- REQ-001 Parameter CLK_FREQ, default 50000000, input clock frequency in Hz.
- REQ-002 Parameter BAUD, default 38400, line bit rate in bits/s.
- REQ-003 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
- REQ-004 Parameter STOP_BITS, default 2, legal values 1 or 2.
- REQ-005 Port clk, input, 1 bit: single clock; all logic on its rising edge.
- REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
- REQ-007 Port wr_en, input, 1 bit: write strobe, one byte per cycle.
- REQ-008 Port wr_data, input, 8 bits: byte to enqueue, sampled when wr_en = 1.
- REQ-009 Port full, output, 1 bit: FIFO holds 8 bytes.
- REQ-010 Port count, output, 4 bits: number of bytes queued, 0..8.
- REQ-011 Port TxD, output, 1 bit: serial line, registered, idle high.
- REQ-012 Port TxD_busy, output, 1 bit: high when the FSM is not IDLE or count != 0.

Function
- REQ-013 SHALL derive BIT_CYCLES = (CLK_FREQ + BAUD/2)/BAUD.
- REQ-014 Every line bit SHALL last exactly BIT_CYCLES clocks.
- REQ-015 FIFO SHALL be 8 entries deep with 3-bit read/write pointers that wrap 7 -> 0.
- REQ-016 A write with wr_en = 1 and full = 0 SHALL enqueue wr_data and increment count at the same edge.
- REQ-017 A write with full = 1 SHALL be dropped and leave count unchanged, even if a pop occurs in the same cycle.
- REQ-018 A simultaneous accepted write and pop SHALL leave count unchanged.
- REQ-019 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
- REQ-020 IDLE with count > 0: at the next edge, SHALL pop the head byte into the shift register, decrement count, clear the bit counter and go to START.
- REQ-021 START SHALL drive TxD = 0 for one bit time.
- REQ-022 DATA SHALL send 8 bits LSB first, one bit per bit time.
- REQ-023 PARITY SHALL send one bit only when PARITY != 0: XOR of the data bits for even, its inverse for odd. With PARITY = 0 the FSM SHALL go from DATA directly to STOP.
- REQ-024 STOP SHALL drive TxD = 1 for STOP_BITS bit times, then go to IDLE.
- REQ-025 Between frames, TxD SHALL be high for exactly one IDLE cycle when data is queued.
- REQ-026 TxD SHALL change only at bit-time boundaries while a frame is in progress.
- REQ-027 Frame length in clocks SHALL be (1 + 8 + (PARITY != 0) + STOP_BITS) * BIT_CYCLES.
- REQ-028 The shifted byte SHALL be held internally, so FIFO writes during a frame do not disturb it.

Reset
- REQ-029 While rst = 1: count = 0, full = 0, pointers = 0, FSM = IDLE, bit and baud counters = 0, TxD = 1, TxD_busy = 0.
- REQ-030 rst asserted mid-frame SHALL abort the frame; TxD = 1 from the cycle after the reset edge.
- REQ-031 rst asserted mid-frame SHALL discard all queued bytes.
- REQ-032 wr_en SHALL be ignored during any cycle with rst = 1.

Verification (CLK_FREQ = 1600, BAUD = 100, BIT_CYCLES = 16)
- REQ-033 PARITY = 0, STOP_BITS = 2, write 0x55 from idle -> TxD sequence 0,1,0,1,0,1,0,1,0,1,1, each bit 16 clocks; frame 176 clocks; TxD_busy falls at the end of the frame.
- REQ-034 PARITY = 2, write 0x07 -> parity bit = 1, frame 192 clocks. PARITY = 1, write 0x07 -> parity bit = 0.
- REQ-035 While a frame is in progress, write 9 bytes 0x10..0x18 on consecutive cycles -> full asserts after the 8th write with count = 8; 0x18 is dropped; exactly 8 further frames follow, carrying 0x10..0x17 in order.
- REQ-036 Two bytes queued -> second frame START begins exactly one IDLE cycle after the first frame's final stop bit ends.
- REQ-037 Pulse rst during bit 3 of a frame with 3 bytes queued -> TxD = 1 and count = 0 the next cycle; no further frames are sent.
- REQ-038 With full = 1, apply wr_en in the same cycle as an IDLE pop -> count goes 8 -> 7 and the write is dropped.
